// File: rtl/switch_load_ctrl_pkg.sv
// Shared types for the switch-load front end: debounce FSM state encoding.
package switch_load_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPress   = 2'd1,
        StHeld    = 2'd2,
        StRelease = 2'd3
    } state_e;

    function automatic logic is_pressed(state_e s);
        return (s == StHeld) || (s == StRelease);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Reset-to-0 flop chain that brings one asynchronous bit into the clk domain.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/switch_load_ctrl.sv
// Synchronises switches and a pushbutton, debounces the button and emits one
// registered load strobe with the captured switch value per debounced press.
module switch_load_ctrl
    import switch_load_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic [WIDTH-1:0] sw_raw,
    output logic             load,
    output logic [WIDTH-1:0] D,
    output logic             pressed
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    // The state-entry edge is the first stable cycle, so the counter stops one short.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             btn_s;
    logic [WIDTH-1:0] sw_s;
    state_e           state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (btn_s)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_sync_sw
        sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (sw_raw[i]),
            .q     (sw_s[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            cnt     <= '0;
            load    <= 1'b0;
            D       <= '0;
            pressed <= 1'b0;
        end else begin
            load    <= 1'b0;
            pressed <= is_pressed(state);
            unique case (state)
                StIdle: begin
                    if (btn_s) begin
                        state <= StPress;
                        cnt   <= '0;
                    end
                end
                StPress: begin
                    if (!btn_s) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= StHeld;
                        cnt   <= '0;
                        load  <= 1'b1;
                        D     <= sw_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StHeld: begin
                    if (!btn_s) begin
                        state <= StRelease;
                        cnt   <= '0;
                    end
                end
                StRelease: begin
                    if (btn_s) begin
                        state <= StHeld;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_load_ctrl.sv
// Directed bench for switch_load_ctrl with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_switch_load_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic [4:0] sw_raw;
    logic       load;
    logic [4:0] D;
    logic       pressed;

    int n_cmp  = 0;
    int n_fail = 0;

    int   load_count = 0;
    logic load_prev  = 1'b0;
    logic back2back  = 1'b0;

    switch_load_ctrl #(
        .WIDTH           (5),
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .sw_raw  (sw_raw),
        .load    (load),
        .D       (D),
        .pressed (pressed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load) load_count++;
        if (load && load_prev) back2back = 1'b1;
        load_prev = load;
    end

    typedef struct {
        logic       btn;
        logic [4:0] sw;
        int         steps;
        logic       exp_load;
        logic [4:0] exp_d;
        logic       exp_pressed;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic el, input logic [4:0] ed,
                              input logic ep);
        check({name, ".load"}, 32'(load), 32'(el));
        check({name, ".D"}, 32'(D), 32'(ed));
        check({name, ".pressed"}, 32'(pressed), 32'(ep));
    endtask

    int base;

    initial begin
        //            btn   sw        steps load D         pressed
        vecs[0]  = '{1'b1, 5'b10110, 5,  1'b0, 5'b00000, 1'b0};
        vecs[1]  = '{1'b1, 5'b10110, 1,  1'b1, 5'b10110, 1'b0};
        vecs[2]  = '{1'b1, 5'b10110, 1,  1'b0, 5'b10110, 1'b1};
        vecs[3]  = '{1'b1, 5'b00011, 50, 1'b0, 5'b10110, 1'b1};
        vecs[4]  = '{1'b1, 5'b00011, 44, 1'b0, 5'b10110, 1'b1};
        vecs[5]  = '{1'b0, 5'b00011, 2,  1'b0, 5'b10110, 1'b1};
        vecs[6]  = '{1'b1, 5'b00011, 2,  1'b0, 5'b10110, 1'b1};
        vecs[7]  = '{1'b1, 5'b00011, 5,  1'b0, 5'b10110, 1'b1};
        vecs[8]  = '{1'b0, 5'b00011, 10, 1'b0, 5'b10110, 1'b0};
        vecs[9]  = '{1'b1, 5'b00011, 5,  1'b0, 5'b10110, 1'b0};
        vecs[10] = '{1'b1, 5'b00011, 1,  1'b1, 5'b00011, 1'b0};
        vecs[11] = '{1'b1, 5'b00011, 1,  1'b0, 5'b00011, 1'b1};
        vecs[12] = '{1'b0, 5'b00011, 10, 1'b0, 5'b00011, 1'b0};

        // Reset asserted with the button held and switches moving
        rst_n   = 1'b1;
        btn_raw = 1'b1;
        sw_raw  = 5'h1F;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check_outs("reset_async", 1'b0, 5'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sw_raw = ~sw_raw;
            step();
            check_outs("reset_hold", 1'b0, 5'h00, 1'b0);
        end
        btn_raw = 1'b0;
        sw_raw  = 5'b10110;
        step();
        rst_n = 1'b1;
        step();
        base = load_count;

        // Press, long hold with switch change, release bounce, second press
        for (int i = 0; i < 13; i++) begin
            btn_raw = vecs[i].btn;
            sw_raw  = vecs[i].sw;
            repeat (vecs[i].steps) step();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_load, vecs[i].exp_d,
                       vecs[i].exp_pressed);
        end
        check("loads_after_table", 32'(load_count - base), 32'd2);

        // Press bounce: 2 high / 2 low never survives the debounce
        for (int i = 0; i < 10; i++) begin
            btn_raw = 1'b1;
            repeat (2) step();
            btn_raw = 1'b0;
            repeat (2) step();
        end
        repeat (10) step();
        check("loads_after_bounce", 32'(load_count - base), 32'd2);
        check_outs("after_bounce", 1'b0, 5'b00011, 1'b0);

        // Reset mid-PRESS (cnt=2), button kept high through reset release
        btn_raw = 1'b1;
        repeat (5) step();
        check_outs("mid_press", 1'b0, 5'b00011, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outs("mid_press_reset", 1'b0, 5'h00, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        check_outs("post_reset_wait", 1'b0, 5'h00, 1'b0);
        step();
        check_outs("post_reset_load", 1'b1, 5'b00011, 1'b0);
        step();
        check_outs("post_reset_held", 1'b0, 5'b00011, 1'b1);
        check("loads_total", 32'(load_count - base), 32'd3);
        check("no_back_to_back", 32'(back2back), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
